// File: rtl/switch_debounce_if.sv
// Switch bundle between the push-button conditioner and the mode/animation state machine.
// The slave side is the conditioner; the master side drives the raw button levels.
interface switch_debounce_if;
    logic [3:0] i_Switches;
    logic [3:0] o_Switches;
    logic [3:0] o_Press;
    logic [3:0] o_Release;
    logic [3:0] o_Hold;

    modport master (
        output i_Switches,
        input  o_Switches,
        input  o_Press,
        input  o_Release,
        input  o_Hold
    );

    modport slave (
        input  i_Switches,
        output o_Switches,
        output o_Press,
        output o_Release,
        output o_Hold
    );
endinterface

// File: rtl/switch_debounce.sv
// Four-channel push-button conditioner: 2-flop synchroniser, stability counter, press/release pulses.
// Long-press (o_Hold) detection is built only when SWITCH_DEBOUNCE_HOLD_EN is defined.
module switch_debounce #(
    parameter int g_DEBOUNCE_LIMIT = 250000,
    parameter int g_HOLD_DELAY     = 75000000
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    switch_debounce_if.slave   sw_if
);

    localparam int              CW    = $clog2(g_DEBOUNCE_LIMIT + 1);
    localparam logic [CW-1:0]   LIMIT = CW'(g_DEBOUNCE_LIMIT);

    if (g_DEBOUNCE_LIMIT < 1 || g_HOLD_DELAY < 0) begin : g_bad_param
        $error("switch_debounce: g_DEBOUNCE_LIMIT must be >= 1 and g_HOLD_DELAY >= 0");
    end

    logic [3:0] sync1_q, sync2_q;
    logic [3:0] sw_q, sw_d;
    logic [3:0] press_q, press_d;
    logic [3:0] release_q, release_d;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            sw_q      <= '0;
            press_q   <= '0;
            release_q <= '0;
        end else begin
            sync1_q   <= sw_if.i_Switches;
            sync2_q   <= sync1_q;
            sw_q      <= sw_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_ch
        logic [CW-1:0] cnt_q, cnt_d;
        logic          differs;
        logic          expired;

        assign differs = (sync2_q[gi] != sw_q[gi]);
        // The counter only reaches LIMIT after LIMIT consecutive mismatches; one more flips the level.
        assign expired = differs && (cnt_q == LIMIT);

        always_comb begin
            cnt_d = '0;
            if (differs && !expired) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign sw_d[gi]      = expired ? sync2_q[gi] : sw_q[gi];
        assign press_d[gi]   = expired &  sync2_q[gi];
        assign release_d[gi] = expired & ~sync2_q[gi];
    end

    assign sw_if.o_Switches = sw_q;
    assign sw_if.o_Press    = press_q;
    assign sw_if.o_Release  = release_q;

`ifdef SWITCH_DEBOUNCE_HOLD_EN
    localparam logic [31:0] HOLD = 32'(g_HOLD_DELAY);

    logic [3:0] hold_q, hold_d;

    for (genvar gi = 0; gi < 4; gi++) begin : g_hold
        logic [31:0] hcnt_q, hcnt_d;
        logic        fired_q, fired_d;
        logic        hold_ch;

        // Counting starts the cycle after the press pulse and freezes at HOLD; fired_q limits one pulse per press.
        always_comb begin
            hcnt_d  = '0;
            fired_d = 1'b0;
            hold_ch = 1'b0;
            if (sw_q[gi]) begin
                hcnt_d  = hcnt_q;
                fired_d = fired_q;
                if (hcnt_q == HOLD) begin
                    if (!fired_q) begin
                        hold_ch = 1'b1;
                        fired_d = 1'b1;
                    end
                end else begin
                    hcnt_d = hcnt_q + 32'd1;
                end
            end
        end

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                hcnt_q  <= '0;
                fired_q <= 1'b0;
            end else begin
                hcnt_q  <= hcnt_d;
                fired_q <= fired_d;
            end
        end

        assign hold_d[gi] = hold_ch;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

    assign sw_if.o_Hold = hold_q;
`else
    assign sw_if.o_Hold = 4'b0000;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Randomised and directed bench for switch_debounce against a sliding-window reference model.
module tb_switch_debounce;
    localparam int LIM  = 4;
    localparam int HOLD = 10;
`ifdef SWITCH_DEBOUNCE_HOLD_EN
    localparam bit HOLD_ON = 1'b1;
`else
    localparam bit HOLD_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    switch_debounce_if sw_if ();

    switch_debounce #(
        .g_DEBOUNCE_LIMIT(LIM),
        .g_HOLD_DELAY    (HOLD)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst),
        .sw_if(sw_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the stable level flips once the last LIM+1 synchronised samples all disagree with it.
    logic [3:0] m_stable, m_press, m_rel, m_hold;
    logic [3:0] samp0, samp1;
    logic [3:0] hist[$];
    int         since[4];

    task automatic model_reset();
        m_stable = '0; m_press = '0; m_rel = '0; m_hold = '0;
        samp0 = '0; samp1 = '0;
        hist.delete();
        for (int n = 0; n < 4; n++) since[n] = 0;
    endtask

    task automatic model_edge(input logic [3:0] sw);
        bit all_diff;
        hist.push_back(samp1);
        if (hist.size() > LIM + 1) void'(hist.pop_front());
        m_press = '0;
        m_rel   = '0;
        for (int n = 0; n < 4; n++) begin
            if (m_stable[n]) begin
                since[n]++;
                m_hold[n] = HOLD_ON && (since[n] == HOLD + 1);
            end else begin
                m_hold[n] = 1'b0;
            end
        end
        for (int n = 0; n < 4; n++) begin
            if (hist.size() == LIM + 1) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][n] == m_stable[n]) all_diff = 1'b0;
                if (all_diff) begin
                    m_stable[n] = ~m_stable[n];
                    m_press[n]  = m_stable[n];
                    m_rel[n]    = ~m_stable[n];
                    since[n]    = 0;
                end
            end
        end
        samp1 = samp0;
        samp0 = sw;
    endtask

    task automatic tick(input logic [3:0] sw);
        @(negedge clk);
        sw_if.i_Switches = sw;
        @(posedge clk);
        model_edge(sw);
        #1;
        check_eq("o_Switches", {28'd0, sw_if.o_Switches}, {28'd0, m_stable});
        check_eq("o_Press",    {28'd0, sw_if.o_Press},    {28'd0, m_press});
        check_eq("o_Release",  {28'd0, sw_if.o_Release},  {28'd0, m_rel});
        check_eq("o_Hold",     {28'd0, sw_if.o_Hold},     {28'd0, m_hold});
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_sw"},   {28'd0, sw_if.o_Switches}, 32'd0);
        check_eq({tag, "_pr"},   {28'd0, sw_if.o_Press},    32'd0);
        check_eq({tag, "_rl"},   {28'd0, sw_if.o_Release},  32'd0);
        check_eq({tag, "_hold"}, {28'd0, sw_if.o_Hold},     32'd0);
    endtask

    // Called right after a tick (posedge+1): asserts reset mid-cycle, releases it after the next edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        model_reset();
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    int         lat;
    logic [3:0] seen;
    logic [3:0] cur;
    int         hold_idx, hold_cnt;

    initial begin
        sw_if.i_Switches = 4'b0000;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_zero("rst_init");
        @(posedge clk);
        #2 rst = 1'b0;

        // Press on channel 0: the 7th sampling edge produces the change.
        lat = 0; seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick(4'b0001);
            if (sw_if.o_Press != 4'b0000) begin lat = i + 1; seen = sw_if.o_Press; break; end
        end
        check_eq("press_lat", lat, 7);
        check_eq("press_val", {28'd0, seen}, 32'h1);
        tick(4'b0001);
        check_eq("press_once", {28'd0, sw_if.o_Press}, 32'h0);

        // Bounces on channel 1 shorter than LIM+1 samples are rejected.
        seen = '0;
        for (int i = 0; i < 3; i++) begin tick(4'b0011); seen |= sw_if.o_Press | sw_if.o_Release; end
        tick(4'b0001); seen |= sw_if.o_Press | sw_if.o_Release;
        for (int i = 0; i < 4; i++) begin tick(4'b0011); seen |= sw_if.o_Press | sw_if.o_Release; end
        for (int i = 0; i < 8; i++) begin tick(4'b0001); seen |= sw_if.o_Press | sw_if.o_Release; end
        check_eq("bounce_pulses", {28'd0, seen}, 32'h0);
        check_eq("bounce_level", {31'd0, sw_if.o_Switches[1]}, 32'h0);

        // Release of channel 0.
        lat = 0; seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick(4'b0000);
            if (sw_if.o_Release != 4'b0000) begin lat = i + 1; seen = sw_if.o_Release; break; end
        end
        check_eq("release_lat", lat, 7);
        check_eq("release_val", {28'd0, seen}, 32'h1);

        // Simultaneous press on channels 2 and 3, then hold channel 3 for 40 cycles.
        repeat (6) tick(4'b0000);
        lat = 0; seen = '0;
        for (int i = 0; i < 12; i++) begin
            tick(4'b1100);
            if (sw_if.o_Press != 4'b0000) begin lat = i + 1; seen = sw_if.o_Press; break; end
        end
        check_eq("simul_lat", lat, 7);
        check_eq("simul_val", {28'd0, seen}, 32'hC);
        hold_idx = 0; hold_cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(4'b1100);
            if (sw_if.o_Hold[3]) begin
                hold_cnt++;
                if (hold_idx == 0) hold_idx = i;
            end
        end
        check_eq("hold_count", hold_cnt, HOLD_ON ? 1 : 0);
        check_eq("hold_delay", hold_idx, HOLD_ON ? HOLD + 1 : 0);
        repeat (10) tick(4'b0000);

        // Reset while channel 2 counter sits at 3; the press restarts from scratch.
        repeat (5) tick(4'b0100);
        async_reset();
        lat = 0;
        for (int i = 0; i < 12; i++) begin
            tick(4'b0100);
            if (sw_if.o_Press[2]) begin lat = i + 1; break; end
        end
        check_eq("rst_mid_lat", lat, 7);
        repeat (8) tick(4'b0000);

        // Random bouncing with occasional asynchronous resets.
        cur = '0;
        for (int it = 0; it < 400; it++) begin
            cur = cur ^ 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            for (int k = $urandom_range(1, 9); k > 0; k--) tick(cur);
            if ($urandom_range(0, 49) == 0) async_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got=%0d exp=finish", total);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
- Four-channel push-button conditioner that sits directly upstream of the mode/animation state machine.
- Drives its switch inputs with clean, synchronised levels.
- Also provides one-cycle press and release pulses, so the downstream stage can use registered pulses instead of detecting raw edges itself.
- Each channel is independent: a 2-flop synchroniser, then a stability counter, then edge pulses.

Parameters:
- g_DEBOUNCE_LIMIT, 250000, number of consecutive cycles the synchronised input must differ from the stable level before the stable level changes (10 ms at 25 MHz); must be >= 1.
- g_HOLD_DELAY, 75000000, number of cycles the stable level must stay high before o_Hold pulses (3 s at 25 MHz); used only when SWITCH_DEBOUNCE_HOLD_EN is defined.

Ports:
- i_Clk  input  1  system clock, 25 MHz.
- i_Rst  input  1  asynchronous, active-high reset.
- i_Switches  input  4  raw, asynchronous button levels; 1 = pressed.
- o_Switches  output  4  debounced stable level per channel.
- o_Press  output  4  one-cycle pulse when o_Switches[n] goes 0->1.
- o_Release  output  4  one-cycle pulse when o_Switches[n] goes 1->0.
- o_Hold  output  4  one-cycle long-press pulse (see Optional Feature).

Behaviour:
- Reset: i_Rst asynchronously clears every register:
  - synchroniser flops, counters, o_Switches, o_Press, o_Release and o_Hold all go to 0.
  - Release of reset takes effect on the next i_Clk rising edge.
- Synchroniser: sync1[n] <= i_Switches[n]; sync2[n] <= sync1[n]. Only sync2 is used downstream.
- Counter per channel: width $clog2(g_DEBOUNCE_LIMIT+1), saturating behaviour not needed. Each edge:
  - If sync2 == o_Switches: counter <= 0.
  - Else if counter == g_DEBOUNCE_LIMIT: o_Switches <= sync2 and counter <= 0.
  - Else: counter <= counter + 1.
- Latency: a clean input transition first sampled by sync1 on edge E appears on o_Switches at edge E + g_DEBOUNCE_LIMIT + 2.
  - Example: 7 edges after sampling when g_DEBOUNCE_LIMIT = 4, i.e. o_Switches changes on edge E+6.
- Glitch rejection: any cycle where sync2 returns to the stable level clears the counter. The stable level changes only after g_DEBOUNCE_LIMIT+1 consecutive mismatching cycles.
- Edge pulses:
  - o_Press[n] is registered high for exactly the one cycle in which o_Switches[n] has just become 1.
  - o_Release[n] behaves the same way for the transition to 0.
  - o_Press and o_Release are never both high on one channel.
- Independence: channels share no state. Simultaneous transitions on several channels produce pulses in the same cycle.
- Reset mid-operation: a partially counted transition is discarded. If the button is still held after reset, it is reported as a fresh press after the full latency.
- Counter values never exceed g_DEBOUNCE_LIMIT; there is no wrap-around.

Optional Feature:
- Macro: SWITCH_DEBOUNCE_HOLD_EN.
- Defined:
  - Each channel has a hold counter, 32 bits wide, cleared while o_Switches[n] == 0.
  - While o_Switches[n] == 1, the counter increments each cycle starting the cycle after the o_Press[n] pulse.
  - When the counter equals g_HOLD_DELAY, o_Hold[n] pulses for one cycle, i.e. g_HOLD_DELAY+1 cycles after o_Press[n].
  - The counter then stops; at most one o_Hold pulse is produced per press.
  - Release clears the counter; reset clears counter and output.
- Not defined: o_Hold is tied to 4'b0000, no hold logic is synthesised, and the port list is unchanged.

Test Plan:
- All tests use g_DEBOUNCE_LIMIT=4 and g_HOLD_DELAY=10.
- Reset and press: assert i_Rst, then check all outputs are 0. Release i_Rst, drive i_Switches=4'b0001 and hold it, with sampling edge E. Required: o_Switches=4'b0001 from edge E+6, o_Press=4'b0001 for exactly that one cycle, and o_Release stays 0.
- Bounce rejection: drive i_Switches[1]=1 for 3 cycles then 0, then 1 for 4 cycles then 0. Required: o_Switches[1] stays 0 and no o_Press or o_Release pulse occurs.
- Release: after the press test, drive i_Switches[0]=0 and hold it. Required: o_Switches[0] falls and o_Release[0] pulses once, 7 edges after sampling.
- Simultaneous: drive i_Switches from 4'b0000 to 4'b1100 in one cycle. Required: o_Press=4'b1100 in a single cycle.
- Reset mid-count: hold i_Switches[2]=1, then pulse i_Rst asynchronously when the channel-2 counter is at 3. Required: all outputs go to 0 immediately, and o_Press[2] pulses exactly 7 edges after the first post-reset sampling edge.
- Hold (macro defined): hold i_Switches[3]=1 for 40 cycles. Required: o_Hold[3] pulses exactly once, 11 cycles after the o_Press[3] pulse. With the macro undefined, o_Hold stays 4'b0000.
